// File: rtl/cpci_reprog_pkg.sv
// ---------------------------------------------------------------------------
// cpci_reprog_pkg
// Shared definitions for the CPCI reprogramming engine:
//   - state_t          : configuration state machine encoding
//   - cfg_width_legal  : legality check for the configuration port width
//   - map_slice        : per-byte bit reversal of an outgoing slice
//   - max_of           : constant helper for counter sizing
// ---------------------------------------------------------------------------
package cpci_reprog_pkg;

    localparam int MAX_CFG_WIDTH = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PROG_LOW,
        ST_WAIT_INIT,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_STARTUP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // The port is serial or a SelectMAP bus, and a host word must split into
    // a whole number of slices.
    function automatic bit cfg_width_legal(input int cfg_width, input int data_width);
        return (cfg_width == 1 || cfg_width == 8 || cfg_width == 16 || cfg_width == 32) &&
               (data_width % cfg_width == 0);
    endfunction

    // SelectMAP expects D0 as the MSB of each byte, so bit_swap mirrors every
    // byte of the slice. A serial port has no byte lanes, so the swap is
    // ignored there.
    function automatic logic [MAX_CFG_WIDTH-1:0] map_slice(
        input logic [MAX_CFG_WIDTH-1:0] raw,
        input int                       cfg_width,
        input logic                     bit_swap
    );
        logic [MAX_CFG_WIDTH-1:0] swapped;
        for (int i = 0; i < MAX_CFG_WIDTH; i++) begin
            swapped[i] = raw[(i / 8) * 8 + 7 - (i % 8)];
        end
        return (bit_swap && cfg_width >= 8) ? swapped : raw;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpci_reprog_fifo.sv
// ---------------------------------------------------------------------------
// cpci_reprog_fifo
// Synchronous first-word-fall-through FIFO holding bitstream words.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; a write in the same cycle is dropped
//   wr_en      : write strobe (accepted when not full, or full with a pop)
//   wr_data    : word to store
//   rd_en      : pop the head word
//   rd_data    : head word (valid when !empty)
//   full/empty : occupancy flags
//   level      : number of words held
// ---------------------------------------------------------------------------
module cpci_reprog_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("cpci_reprog_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (level == (AW + 1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a write to a full FIFO
    // alongside a pop is still accepted.
    assign wr_ok = wr_en && !flush && (!full || rd_en);
    assign rd_ok = rd_en && !flush && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and a resettable array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cpci_reprog_engine.sv
// ---------------------------------------------------------------------------
// cpci_reprog_engine
// Virtex configuration engine. Host words are queued in a FIFO. On
// ctrl_reset the engine pulses PROG_B and waits for INIT_B. It then shifts
// each word out MSB-first on cfg_d with a generated CCLK. When DONE is seen
// it issues the startup clocks.
//   clk, rst_n            : system clock, asynchronous active-low reset
//   ctrl_reset            : one-cycle pulse, restarts programming, flushes FIFO
//   bit_swap              : mirror each byte of a slice (SelectMAP ordering)
//   wr_en, wr_data        : host word write
//   fifo_full, fifo_level : FIFO status
//   busy, done, error     : engine status (done/error sticky until ctrl_reset)
//   overflow              : sticky, a write was dropped on a full FIFO
//   cfg_prog_b            : PROG_B pin
//   cfg_init_b, cfg_done  : INIT_B / DONE pins (asynchronous)
//   cfg_cclk, cfg_d       : configuration clock and data
// ---------------------------------------------------------------------------
module cpci_reprog_engine
    import cpci_reprog_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CFG_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int CCLK_DIV      = 2,
    parameter int PROG_PULSE    = 64,
    parameter int INIT_TIMEOUT  = 4096,
    parameter int STARTUP_CCLKS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ctrl_reset,
    input  logic                            bit_swap,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic                            overflow,
    output logic                            cfg_prog_b,
    input  logic                            cfg_init_b,
    input  logic                            cfg_done,
    output logic                            cfg_cclk,
    output logic [CFG_WIDTH-1:0]            cfg_d
);

    localparam int NUM_SLICES = DATA_WIDTH / CFG_WIDTH;
    localparam int IDX_W      = $clog2(NUM_SLICES + 1);
    localparam int CNT_W      = $clog2(max_of(max_of(PROG_PULSE, INIT_TIMEOUT), CCLK_DIV) + 1);
    localparam int SU_W       = $clog2(STARTUP_CCLKS + 1);

    if (!cfg_width_legal(CFG_WIDTH, DATA_WIDTH)) begin : g_bad_cfg_width
        $error("cpci_reprog_engine: CFG_WIDTH must be 1, 8, 16 or 32 and divide DATA_WIDTH");
    end

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              init_sync;
    logic [1:0]              done_sync;
    logic                    init_s;
    logic                    done_s;
    logic [CNT_W-1:0]        timer;
    logic                    phase_end;
    logic [IDX_W-1:0]        slice_idx;
    logic                    last_slice;
    logic [DATA_WIDTH-1:0]   word_q;
    logic                    startup_hi;
    logic [SU_W-1:0]         startup_cnt;
    logic                    pop;
    logic                    advance;
    logic                    flush;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;
    logic [MAX_CFG_WIDTH-1:0] raw_slice;
    logic [MAX_CFG_WIDTH-1:0] mapped_slice;
    logic                    unused_slice_bits;

    // Two-flop synchronisers for the asynchronous configuration pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_sync <= '0;
            done_sync <= '0;
        end else begin
            init_sync <= {init_sync[0], cfg_init_b};
            done_sync <= {done_sync[0], cfg_done};
        end
    end

    assign init_s = init_sync[1];
    assign done_s = done_sync[1];

    // Leftover words are discarded once configuration is finished, and
    // writes made after that are absorbed without raising overflow.
    assign flush = ctrl_reset || (state == ST_STARTUP) || (state == ST_DONE);

    cpci_reprog_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign phase_end  = (timer == CNT_W'(CCLK_DIV - 1));
    assign last_slice = (slice_idx == IDX_W'(NUM_SLICES - 1));

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_PROG_LOW: begin
                if (timer == CNT_W'(PROG_PULSE - 1)) state_next = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (init_s)                                 state_next = ST_LOAD;
                else if (timer == CNT_W'(INIT_TIMEOUT - 1)) state_next = ST_ERROR;
            end
            ST_LOAD: begin
                // INIT_B low during loading signals a CRC error; it outranks DONE.
                if (!init_s)          state_next = ST_ERROR;
                else if (done_s)      state_next = ST_STARTUP;
                else if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (!init_s)        state_next = ST_ERROR;
                else if (phase_end) state_next = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (!init_s) begin
                    state_next = ST_ERROR;
                end else if (phase_end) begin
                    if (last_slice) begin
                        state_next = ST_LOAD;
                    end else begin
                        advance    = 1'b1;
                        state_next = ST_SHIFT_LO;
                    end
                end
            end
            ST_STARTUP: begin
                if (phase_end && startup_hi && startup_cnt == SU_W'(STARTUP_CCLKS - 1))
                    state_next = ST_DONE;
            end
            ST_IDLE, ST_DONE, ST_ERROR: begin
            end
            default: state_next = ST_IDLE;
        endcase

        if (ctrl_reset) begin
            state_next = ST_PROG_LOW;
            pop        = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // One timer serves the PROG_B pulse, the INIT_B timeout and the CCLK
    // half-periods. It restarts on every state entry and on each STARTUP
    // half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (ctrl_reset || state_next != state ||
                     (state == ST_STARTUP && phase_end)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startup_hi  <= 1'b0;
            startup_cnt <= '0;
        end else if (state != ST_STARTUP) begin
            startup_hi  <= 1'b0;
            startup_cnt <= '0;
        end else if (phase_end) begin
            startup_hi <= !startup_hi;
            if (startup_hi) startup_cnt <= startup_cnt + 1'b1;
        end
    end

    // The word is held in a shift register. The current slice is always the
    // top CFG_WIDTH bits, which gives MSB-first slice ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            slice_idx <= '0;
        end else if (pop) begin
            word_q    <= fifo_rd_data;
            slice_idx <= '0;
        end else if (advance) begin
            word_q    <= word_q << CFG_WIDTH;
            slice_idx <= slice_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   overflow <= 1'b0;
        else if (ctrl_reset)                          overflow <= 1'b0;
        else if (wr_en && fifo_full && !pop && !flush) overflow <= 1'b1;
    end

    assign raw_slice    = MAX_CFG_WIDTH'(word_q[DATA_WIDTH-1 -: CFG_WIDTH]);
    assign mapped_slice = map_slice(raw_slice, CFG_WIDTH, bit_swap);
    // Bits above CFG_WIDTH are zero padding and are not driven out.
    assign unused_slice_bits = ^mapped_slice;

    always_comb begin
        cfg_d = '0;
        case (state)
            ST_SHIFT_LO, ST_SHIFT_HI: cfg_d = mapped_slice[CFG_WIDTH-1:0];
            ST_STARTUP:               cfg_d = '1;
            default:                  cfg_d = '0;
        endcase
    end

    assign cfg_prog_b = (state != ST_PROG_LOW);
    assign cfg_cclk   = (state == ST_SHIFT_HI) || (state == ST_STARTUP && startup_hi);
    assign busy       = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_cpci_reprog_engine.sv
// ---------------------------------------------------------------------------
// tb_cpci_reprog_engine
// Directed bench for cpci_reprog_engine. One instance uses the 8-bit
// SelectMAP port and a second uses the 1-bit serial port. Both share the
// same stimulus. Monitors count CCLK edges, CCLK-high clocks and PROG_B-low
// clocks, and capture the data seen at each rising CCLK edge.
// ---------------------------------------------------------------------------
module tb_cpci_reprog_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        bit_swap = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        cfg_init_b = 1'b0;
    logic        cfg_done = 1'b0;

    logic        full8, busy8, done8, error8, ovf8, prog_b8, cclk8;
    logic [4:0]  level8;
    logic [7:0]  d8;
    logic        full1, busy1, done1, error1, ovf1, prog_b1, cclk1;
    logic [4:0]  level1;
    logic [0:0]  d1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpci_reprog_engine u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_reset (ctrl_reset),
        .bit_swap   (bit_swap),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (full8),
        .fifo_level (level8),
        .busy       (busy8),
        .done       (done8),
        .error      (error8),
        .overflow   (ovf8),
        .cfg_prog_b (prog_b8),
        .cfg_init_b (cfg_init_b),
        .cfg_done   (cfg_done),
        .cfg_cclk   (cclk8),
        .cfg_d      (d8)
    );

    cpci_reprog_engine #(.CFG_WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_reset (ctrl_reset),
        .bit_swap   (bit_swap),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (full1),
        .fifo_level (level1),
        .busy       (busy1),
        .done       (done1),
        .error      (error1),
        .overflow   (ovf1),
        .cfg_prog_b (prog_b1),
        .cfg_init_b (cfg_init_b),
        .cfg_done   (cfg_done),
        .cfg_cclk   (cclk1),
        .cfg_d      (d1)
    );

    // Monitors: monotonic counters, read as differences by the stimulus.
    int          edges8 = 0;
    int          edges1 = 0;
    int          prog_low8 = 0;
    int          cclk_hi8 = 0;
    logic [7:0]  cap8 [64];
    logic [31:0] bits1 = '0;

    always @(posedge cclk8) begin
        cap8[edges8 % 64] = d8;
        edges8 = edges8 + 1;
    end

    always @(posedge cclk1) begin
        bits1  = {bits1[30:0], d1[0]};
        edges1 = edges1 + 1;
    end

    always @(posedge clk) begin
        if (!prog_b8) prog_low8 = prog_low8 + 1;
        if (cclk8)    cclk_hi8  = cclk_hi8 + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        ctrl_reset = 1'b1;
        step(1);
        ctrl_reset = 1'b0;
    endtask

    task automatic wait_prog_rise(input string tag);
        for (int i = 0; i < 200 && !prog_b8; i++) step(1);
        check(tag, 32'(prog_b8), 32'd1);
    endtask

    initial begin
        int         e0, e1, h0, p0;
        logic [7:0] exp_b [4];

        // ---------------- reset ----------------
        step(3);
        rst_n = 1'b1;
        step(2);
        check("rst_prog_b", 32'(prog_b8), 32'd1);
        check("rst_cclk",   32'(cclk8),   32'd0);
        check("rst_busy",   32'(busy8),   32'd0);
        check("rst_level",  32'(level8),  32'd0);
        check("rst_flags",  32'({done8, error8, ovf8}), 32'd0);
        check("rst_cfg_d",  32'(d8),      32'd0);

        // ---------------- basic word, no swap ----------------
        p0 = prog_low8;
        pulse_reset();
        check("prog_low_busy", 32'(busy8), 32'd1);
        wait_prog_rise("prog_rise_1");
        check("prog_low_cycles", 32'(prog_low8 - p0), 32'd64);
        step(10);
        cfg_init_b = 1'b1;
        e0 = edges8;
        e1 = edges1;
        h0 = cclk_hi8;
        write_word(32'hAA995566);
        check("level_after_write", 32'(level8), 32'd1);
        for (int i = 0; i < 300 && (edges8 - e0) < 4; i++) step(1);
        step(10);
        check("w8_edges", 32'(edges8 - e0), 32'd4);
        check("w8_cclk_hi_clks", 32'(cclk_hi8 - h0), 32'd8);
        exp_b = '{8'hAA, 8'h99, 8'h55, 8'h66};
        for (int k = 0; k < 4; k++)
            check($sformatf("w8_byte%0d", k), 32'(cap8[(e0 + k) % 64]), 32'(exp_b[k]));
        for (int i = 0; i < 400 && (edges1 - e1) < 32; i++) step(1);
        step(10);
        check("w1_edges", 32'(edges1 - e1), 32'd32);
        check("w1_bits", bits1, 32'hAA995566);

        // ---------------- bit_swap ----------------
        bit_swap = 1'b1;
        e0 = edges8;
        e1 = edges1;
        write_word(32'hAA995566);
        for (int i = 0; i < 300 && (edges8 - e0) < 4; i++) step(1);
        step(10);
        exp_b = '{8'h55, 8'h99, 8'hAA, 8'h66};
        for (int k = 0; k < 4; k++)
            check($sformatf("swap_byte%0d", k), 32'(cap8[(e0 + k) % 64]), 32'(exp_b[k]));
        for (int i = 0; i < 400 && (edges1 - e1) < 32; i++) step(1);
        step(10);
        check("swap_w1_bits", bits1, 32'hAA995566);
        bit_swap = 1'b0;

        // ---------------- CRC error mid-word ----------------
        e0 = edges8;
        write_word(32'h12345678);
        for (int i = 0; i < 300 && (edges8 - e0) < 2; i++) step(1);
        cfg_init_b = 1'b0;
        step(3);
        check("crc_cclk_low", 32'(cclk8),  32'd0);
        check("crc_error",    32'(error8), 32'd1);
        check("crc_not_busy", 32'(busy8),  32'd0);
        e0 = edges8;
        step(20);
        check("crc_no_edges", 32'(edges8 - e0), 32'd0);

        // ---------------- FIFO full / overflow ----------------
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'(i);
            step(1);
        end
        wr_en = 1'b0;
        check("fill_full",  32'(full8),  32'd1);
        check("fill_level", 32'(level8), 32'd16);
        check("fill_no_ovf", 32'(ovf8),  32'd0);
        write_word(32'hDEADBEEF);
        check("ovf_set",   32'(ovf8),   32'd1);
        check("ovf_level", 32'(level8), 32'd16);
        ctrl_reset = 1'b1;
        wr_en      = 1'b1;
        step(1);
        ctrl_reset = 1'b0;
        wr_en      = 1'b0;
        check("clr_level", 32'(level8), 32'd0);
        check("clr_full",  32'(full8),  32'd0);
        check("clr_ovf",   32'(ovf8),   32'd0);

        // ---------------- INIT_B timeout ----------------
        e0 = edges8;
        wait_prog_rise("prog_rise_2");
        step(4095);
        check("timeout_not_yet", 32'(error8), 32'd0);
        check("timeout_busy",    32'(busy8),  32'd1);
        step(1);
        check("timeout_error",   32'(error8), 32'd1);
        check("timeout_no_edges", 32'(edges8 - e0), 32'd0);

        // ---------------- DONE mid-stream ----------------
        pulse_reset();
        wait_prog_rise("prog_rise_3");
        step(10);
        cfg_init_b = 1'b1;
        e0 = edges8;
        write_word(32'h01020304);
        write_word(32'h11223344);
        write_word(32'hA5A5A5A5);
        write_word(32'h5A5A5A5A);
        for (int i = 0; i < 300 && (edges8 - e0) < 5; i++) step(1);
        cfg_done = 1'b1;
        for (int i = 0; i < 600 && !done8; i++) step(1);
        step(2);
        check("done_flag",  32'(done8),  32'd1);
        check("done_busy",  32'(busy8),  32'd0);
        check("done_level", 32'(level8), 32'd0);
        check("done_edges", 32'(edges8 - e0), 32'd16);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++)
            check($sformatf("done_w2_byte%0d", k), 32'(cap8[(e0 + 4 + k) % 64]), 32'(exp_b[k]));
        check("startup_first", 32'(cap8[(e0 + 8) % 64]),  32'hFF);
        check("startup_last",  32'(cap8[(e0 + 15) % 64]), 32'hFF);

        // ---------------- ctrl_reset mid-shift ----------------
        cfg_done = 1'b0;
        pulse_reset();
        wait_prog_rise("prog_rise_4");
        e0 = edges8;
        write_word(32'hCAFEF00D);
        for (int i = 0; i < 300 && (edges8 - e0) < 2; i++) step(1);
        check("restart_mid_word", 32'(cclk8), 32'd1);
        ctrl_reset = 1'b1;
        step(1);
        ctrl_reset = 1'b0;
        check("restart_prog_b", 32'(prog_b8), 32'd0);
        check("restart_cclk",   32'(cclk8),   32'd0);
        check("restart_busy",   32'(busy8),   32'd1);
        check("restart_level",  32'(level8),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpci_reprog_engine.md
Name: cpci_reprog_engine

Overview:
- Synthesizable Virtex configuration engine behind the CPCI_REPROG_CTRL and CPCI_REPROG_DATA registers.
- Register decode writes 32-bit bitstream words into an internal FIFO.
- The engine pulses PROG_B, waits for INIT_B, then shifts words out on a parametrised-width configuration port (1-bit serial or 8/16/32-bit SelectMAP) with a generated CCLK.
- It reports done, error and overflow status back to the register file.

Parameters:
- DATA_WIDTH, 32: width of the words written by the host.
- CFG_WIDTH, 8: configuration data port width; one of 1, 8, 16, 32; must divide DATA_WIDTH.
- FIFO_DEPTH, 16: word FIFO depth; power of two, at least 2.
- CCLK_DIV, 2: CLK cycles per CCLK half-period; at least 1.
- PROG_PULSE, 64: CLK cycles that cfg_prog_b is held low.
- INIT_TIMEOUT, 4096: maximum CLK cycles to wait for cfg_init_b to go high.
- STARTUP_CCLKS, 8: extra CCLK pulses issued after cfg_done is seen.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- ctrl_reset  in  1  one-cycle pulse; starts a new programming cycle
- bit_swap  in  1  1 = bit-reverse each byte of a slice (SelectMAP ordering)
- wr_en  in  1  write strobe for a data word
- wr_data  in  DATA_WIDTH  bitstream word
- fifo_full  out  1  FIFO full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words held
- busy  out  1  engine is not in IDLE, DONE or ERROR
- done  out  1  configuration completed (sticky)
- error  out  1  INIT timeout or CRC error (sticky)
- overflow  out  1  a write was dropped because the FIFO was full (sticky)
- cfg_prog_b  out  1  PROG_B pin
- cfg_init_b  in  1  INIT_B pin, asynchronous
- cfg_done  in  1  DONE pin, asynchronous
- cfg_cclk  out  1  configuration clock
- cfg_d  out  CFG_WIDTH  configuration data

Behaviour:
Reset values: cfg_prog_b=1, cfg_cclk=0, cfg_d=0, busy=0, done=0, error=0, overflow=0, FIFO empty. State is IDLE.

Input synchronisation: cfg_init_b and cfg_done pass through two-flop synchronisers. All decisions use the synchronised values (2-cycle latency).

FIFO:
- A write with wr_en=1 and not full is stored the same cycle; fifo_level updates next cycle.
- A write while full is dropped and sets overflow.
- A write and a pop in the same cycle while full succeed; the level is unchanged.
- ctrl_reset empties the FIFO and clears done, error and overflow.

State machine:
- IDLE: outputs idle. ctrl_reset -> PROG_LOW.
- PROG_LOW: cfg_prog_b=0 for exactly PROG_PULSE cycles, then cfg_prog_b=1 -> WAIT_INIT.
- WAIT_INIT: when the synchronised init_b=1 -> LOAD. After INIT_TIMEOUT cycles without it -> ERROR.
- LOAD: cfg_cclk=0.
  - Synchronised done=1 -> STARTUP.
  - FIFO non-empty -> pop the word, slice index=0 -> SHIFT_LO.
  - Otherwise stay in LOAD (stall; CCLK held low).
- SHIFT_LO: cfg_d = current slice, cfg_cclk=0, held for CCLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI: cfg_cclk=1 for CCLK_DIV cycles; cfg_d stays stable.
  - Last slice -> LOAD.
  - Otherwise the slice index increments -> SHIFT_LO.
- STARTUP: STARTUP_CCLKS full CCLK periods with cfg_d=all ones -> DONE.
- DONE: done=1, FIFO writes are still accepted but ignored. ctrl_reset -> PROG_LOW.
- ERROR: error=1, cfg_cclk=0. ctrl_reset -> PROG_LOW.

Slicing:
- Slices go MSB-first: slice k = wr_data[DATA_WIDTH-1-k*CFG_WIDTH -: CFG_WIDTH].
- bit_swap applies per byte only when CFG_WIDTH is at least 8. It is ignored when CFG_WIDTH=1.

CRC error: synchronised init_b=0 in SHIFT_LO, SHIFT_HI or LOAD -> ERROR at the end of the current CLK cycle. No further CCLK edges are issued.

done handling: synchronised done rising mid-word does not abort the word. The current word completes, and LOAD then goes to STARTUP; remaining FIFO words are discarded.

ctrl_reset priority:
- ctrl_reset in any state, including mid-SHIFT, forces PROG_LOW next cycle, cfg_cclk=0 and a FIFO flush.
- A write coincident with ctrl_reset is dropped.

Decomposition:
- Shared package holds the state encoding, the slice-select/bit-swap function and the CFG_WIDTH legality check (elaboration $error).
- One sub-module, cpci_reprog_fifo: a parametrised synchronous FIFO with full, empty and level outputs.

Test Plan:
- Reset release, no stimulus -> cfg_prog_b=1, cfg_cclk=0, busy=0, fifo_level=0.
- CFG_WIDTH=8, CCLK_DIV=2, bit_swap=0: ctrl_reset, init_b high 10 cycles after PROG_B rises, write 32'hAA995566 -> cfg_prog_b low for exactly 64 cycles. Bytes AA, 99, 55, 66 appear on cfg_d at 4 rising CCLK edges, each CCLK high for 2 CLK.
- Same word with bit_swap=1 -> bytes 55, 99, AA, 66. With CFG_WIDTH=1 -> 32 CCLK edges MSB-first.
- init_b held low -> error=1 after 4096 cycles in WAIT_INIT, with no CCLK edges. Pulling init_b low mid-word -> error, CCLK stops within 3 cycles.
- Write 17 words with init_b low (FIFO_DEPTH=16) -> fifo_full=1, overflow=1, fifo_level=16. ctrl_reset clears all three.
- done asserted during the second of 4 words -> the word completes, 8 startup CCLKs follow, done=1, busy=0. A following ctrl_reset mid-shift restarts PROG_LOW.
